// File: rtl/beep_sequencer_pkg.sv
// Shared types and default widths for the beep sequencer slice.
package sound_pkg;

  typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

  typedef enum logic {B_SHORT, B_LONG} beep_t;

  localparam int unsigned FREQ_W_DEF = 52;
  localparam int unsigned CNT_W_DEF  = 24;

endpackage

// File: rtl/beep_sequencer_if.sv
// Request/feedback bundle between the control FSM (master) and the beep sequencer (slave).
//   short, long : beep requests (level; edges are detected inside the sequencer)
//   enable      : tone sounding
//   sonido      : frequency word for the audio driver
//   tone        : internal square wave
//   busy        : sequencer not idle
//   dropped     : one-cycle pulse when a request is discarded
interface beep_sequencer_if import sound_pkg::*; #(
  parameter int unsigned FREQ_W = FREQ_W_DEF
);

  logic              short;
  logic              long;
  logic              enable;
  logic [FREQ_W-1:0] sonido;
  logic              tone;
  logic              busy;
  logic              dropped;

  modport master (
    output short, long,
    input  enable, sonido, tone, busy, dropped
  );

  modport slave (
    input  short, long,
    output enable, sonido, tone, busy, dropped
  );

endinterface

// File: rtl/beep_sequencer_tone_divider.sv
// Square-wave generator for the tone output.
//   clk, reset  : clock and synchronous active-high reset
//   start       : restart phase (counter and output to 0)
//   half_period : half period in clk cycles (>=1)
//   run         : count while high; output forced to 0 while low
//   tone        : square wave
module tone_divider import sound_pkg::*; #(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] half_period,
  input  logic             run,
  output logic             tone
);

  logic [CNT_W-1:0] cnt;
  logic             tone_q;

  always_ff @(posedge clk) begin
    if (reset || start || !run) begin
      cnt    <= '0;
      tone_q <= 1'b0;
    end else if (cnt == half_period - CNT_W'(1)) begin
      cnt    <= '0;
      tone_q <= ~tone_q;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // tone_q can still hold its last phase in the cycle after run falls.
  assign tone = tone_q & run;

endmodule

// File: rtl/beep_sequencer.sv
// Beep sequencer: turns short/long request edges into timed tones, each followed by a
// silent gap, with a one-deep pending slot.
//   clk   : system clock
//   reset : synchronous active-high reset
//   bus   : request/feedback bundle (slave side)
module beep_sequencer import sound_pkg::*; #(
  parameter int unsigned     FREQ_W      = FREQ_W_DEF,
  parameter int unsigned     CNT_W       = CNT_W_DEF,
  parameter int unsigned     SHORT_TICKS = 4,
  parameter int unsigned     LONG_TICKS  = 10,
  parameter int unsigned     GAP_TICKS   = 3,
  parameter longint unsigned FREQ_SHORT  = 32000,
  parameter longint unsigned FREQ_LONG   = 32000,
  parameter int unsigned     HALF_SHORT  = 2,
  parameter int unsigned     HALF_LONG   = 2
) (
  input logic              clk,
  input logic              reset,
  beep_sequencer_if.slave  bus
);

  localparam longint unsigned CNT_LIM = 64'd1 << CNT_W;

  if (CNT_W < 1 || CNT_W > 62) begin : g_bad_cnt_w
    $error("CNT_W out of range");
  end
  if (SHORT_TICKS < 1 || 64'(SHORT_TICKS) >= CNT_LIM) begin : g_bad_short
    $error("SHORT_TICKS out of range");
  end
  if (LONG_TICKS < 1 || 64'(LONG_TICKS) >= CNT_LIM) begin : g_bad_long
    $error("LONG_TICKS out of range");
  end
  if (GAP_TICKS < 1 || 64'(GAP_TICKS) >= CNT_LIM) begin : g_bad_gap
    $error("GAP_TICKS out of range");
  end
  if (HALF_SHORT < 1 || HALF_LONG < 1 || 64'(HALF_SHORT) >= CNT_LIM
      || 64'(HALF_LONG) >= CNT_LIM) begin : g_bad_half
    $error("HALF_SHORT/HALF_LONG out of range");
  end

  state_t           state, state_n;
  beep_t            btype, btype_n;
  beep_t            ptype, ptype_n;
  beep_t            req_type;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] half;
  logic             pend, pend_n;
  logic             short_d, long_d;
  logic             req_s, req_l, has_req;
  logic             offer;
  logic             dropped_q, dropped_n;
  logic             start;

  function automatic logic [CNT_W-1:0] ticks_of(input beep_t t);
    return (t == B_LONG) ? CNT_W'(LONG_TICKS - 1) : CNT_W'(SHORT_TICKS - 1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      btype     <= B_SHORT;
      ptype     <= B_SHORT;
      cnt       <= '0;
      pend      <= 1'b0;
      short_d   <= 1'b0;
      long_d    <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state     <= state_n;
      btype     <= btype_n;
      ptype     <= ptype_n;
      cnt       <= cnt_n;
      pend      <= pend_n;
      short_d   <= bus.short;
      long_d    <= bus.long;
      dropped_q <= dropped_n;
    end
  end

  always_comb begin
    // Long wins a same-cycle tie; the short edge vanishes without a dropped pulse.
    req_l    = bus.long & ~long_d;
    req_s    = bus.short & ~short_d & ~req_l;
    has_req  = req_l | req_s;
    req_type = req_l ? B_LONG : B_SHORT;

    state_n   = state;
    btype_n   = btype;
    ptype_n   = ptype;
    cnt_n     = cnt;
    pend_n    = pend;
    dropped_n = 1'b0;
    start     = 1'b0;
    offer     = 1'b0;

    unique case (state)
      IDLE: begin
        if (has_req) begin
          state_n = TONE;
          btype_n = req_type;
          cnt_n   = ticks_of(req_type);
          start   = 1'b1;
        end
      end
      TONE: begin
        offer = 1'b1;
        if (cnt == '0) begin
          state_n = GAP;
          cnt_n   = CNT_W'(GAP_TICKS - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      GAP: begin
        if (cnt == '0) begin
          if (pend) begin
            // Pending tone starts; a simultaneous new request takes the freed slot.
            state_n = TONE;
            btype_n = ptype;
            cnt_n   = ticks_of(ptype);
            start   = 1'b1;
            pend_n  = has_req;
            if (has_req) ptype_n = req_type;
          end else if (has_req) begin
            state_n = TONE;
            btype_n = req_type;
            cnt_n   = ticks_of(req_type);
            start   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end else begin
          offer = 1'b1;
          cnt_n = cnt - CNT_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    if (offer && has_req) begin
      if (!pend) begin
        pend_n  = 1'b1;
        ptype_n = req_type;
      end else begin
        dropped_n = 1'b1;
        if (ptype == B_SHORT && req_l) ptype_n = B_LONG;
      end
    end
  end

  assign half = (btype == B_LONG) ? CNT_W'(HALF_LONG) : CNT_W'(HALF_SHORT);

  tone_divider #(.CNT_W(CNT_W)) u_tone_divider (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .half_period (half),
    .run         (state == TONE),
    .tone        (bus.tone)
  );

  assign bus.enable  = (state == TONE);
  assign bus.busy    = (state != IDLE);
  assign bus.dropped = dropped_q;
  assign bus.sonido  = (state != TONE) ? '0
                     : (btype == B_LONG) ? FREQ_W'(FREQ_LONG) : FREQ_W'(FREQ_SHORT);

endmodule

// File: tb/tb_beep_sequencer.sv
module tb_beep_sequencer;

  localparam logic [63:0] F_S = 64'd32000;
  localparam logic [63:0] F_L = 64'd48000;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  beep_sequencer_if bus ();

  beep_sequencer #(
    .FREQ_LONG (48000)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, leave the caller at the falling edge.
  task automatic cyc(input logic s, input logic l, input logic r);
    @(posedge clk);
    #1;
    bus.short = s;
    bus.long  = l;
    reset     = r;
    @(negedge clk);
  endtask

  // HALF=2: tone is low for the first two cycles of a tone, high for the next two, and so on.
  function automatic logic tone_at(input int c, input int ts, input logic en);
    return en && ((((c - ts) / 2) % 2) == 1);
  endfunction

  task automatic expect_cyc(input string t, input int c, input logic en, input logic lng,
                            input int ts, input logic bs, input logic dr);
    logic [63:0] f;
    f = en ? (lng ? F_L : F_S) : 64'd0;
    check($sformatf("%s.enable@%0d", t, c), 64'(bus.enable), 64'(en));
    check($sformatf("%s.sonido@%0d", t, c), 64'(bus.sonido), f);
    check($sformatf("%s.tone@%0d", t, c), 64'(bus.tone), 64'(tone_at(c, ts, en)));
    check($sformatf("%s.busy@%0d", t, c), 64'(bus.busy), 64'(bs));
    check($sformatf("%s.dropped@%0d", t, c), 64'(bus.dropped), 64'(dr));
  endtask

  task automatic do_reset(input string t, input logic hold_short);
    @(posedge clk);
    #1;
    reset     = 1'b1;
    bus.short = hold_short;
    bus.long  = 1'b0;
    @(posedge clk);
    @(negedge clk);
    expect_cyc({t, ".rst"}, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    logic en, en_s, en_l, en2;
    int   ts;
    reset     = 1'b1;
    bus.short = 1'b0;
    bus.long  = 1'b0;

    // Single short pulse from IDLE.
    do_reset("short", 1'b0);
    for (int c = 0; c < 10; c++) begin
      cyc(c == 0, 1'b0, 1'b0);
      en = (c >= 1 && c <= 4);
      expect_cyc("short", c, en, 1'b0, 1, (c >= 1 && c <= 7), 1'b0);
    end

    // Long held for 20 cycles: exactly one tone.
    do_reset("held", 1'b0);
    for (int c = 0; c < 25; c++) begin
      cyc(1'b0, c < 20, 1'b0);
      en = (c >= 1 && c <= 10);
      expect_cyc("held", c, en, 1'b1, 1, (c >= 1 && c <= 13), 1'b0);
    end

    // Short, long queued, second short dropped.
    do_reset("queue", 1'b0);
    for (int c = 0; c < 24; c++) begin
      cyc(c == 0 || c == 3, c == 2, 1'b0);
      en_s = (c >= 1 && c <= 4);
      en_l = (c >= 8 && c <= 17);
      ts   = en_l ? 8 : 1;
      expect_cyc("queue", c, en_s | en_l, en_l, ts, (c >= 1 && c <= 20), c == 4);
    end

    // Request on the last gap cycle with an empty slot: back-to-back tones.
    do_reset("lastgap", 1'b0);
    for (int c = 0; c < 17; c++) begin
      cyc(c == 0 || c == 7, 1'b0, 1'b0);
      en  = (c >= 1 && c <= 4);
      en2 = (c >= 8 && c <= 11);
      ts  = en2 ? 8 : 1;
      expect_cyc("lastgap", c, en | en2, 1'b0, ts, (c >= 1 && c <= 14), 1'b0);
    end

    // Gap expiry with a full slot and a new request: new request takes the freed slot.
    do_reset("refill", 1'b0);
    for (int c = 0; c < 30; c++) begin
      cyc(c == 0 || c == 7, c == 2, 1'b0);
      en_s = (c >= 1 && c <= 4) || (c >= 21 && c <= 24);
      en_l = (c >= 8 && c <= 17);
      ts   = (c < 8) ? 1 : ((c < 21) ? 8 : 21);
      expect_cyc("refill", c, en_s | en_l, en_l, ts, (c >= 1 && c <= 27), 1'b0);
    end

    // Reset mid long tone with a short pending: everything silent afterwards.
    do_reset("midrst", 1'b0);
    for (int c = 0; c < 21; c++) begin
      cyc(c == 2, c == 0, c == 5);
      en = (c >= 1 && c <= 5);
      expect_cyc("midrst", c, en, 1'b1, 1, en, 1'b0);
    end

    // Short and long in the same cycle: long wins, nothing dropped.
    do_reset("tie", 1'b0);
    for (int c = 0; c < 16; c++) begin
      cyc(c == 0, c == 0, 1'b0);
      en = (c >= 1 && c <= 10);
      expect_cyc("tie", c, en, 1'b1, 1, (c >= 1 && c <= 13), 1'b0);
    end

    // Pending short overwritten by long, then same-type long dropped.
    do_reset("ovr", 1'b0);
    for (int c = 0; c < 24; c++) begin
      cyc(c == 0 || c == 2, c == 3 || c == 5, 1'b0);
      en_s = (c >= 1 && c <= 4);
      en_l = (c >= 8 && c <= 17);
      ts   = en_l ? 8 : 1;
      expect_cyc("ovr", c, en_s | en_l, en_l, ts, (c >= 1 && c <= 20), c == 4 || c == 6);
    end

    // Short held high through reset counts as an edge right after reset.
    do_reset("thru", 1'b1);
    for (int c = 0; c < 10; c++) begin
      cyc(1'b1, 1'b0, 1'b0);
      en = (c >= 1 && c <= 4);
      expect_cyc("thru", c, en, 1'b0, 1, (c >= 1 && c <= 7), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
